// File: rtl/select_skid.sv
// -----------------------------------------------------------------------------
// select_skid
//
// N-way channel selector with per-channel sign/zero extension, a registered
// output stage and a one-entry skid register, giving a two-deep valid/ready
// pipeline that sustains one transfer per cycle with no combinational path
// from out_ready to in_ready.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous, active-high reset
//   in_data      IN_CNT packed channels, channel i at [i*IN_WIDTH +: IN_WIDTH]
//   in_sel       channel select; values >= IN_CNT are out of range
//   in_valid     upstream transfer request
//   in_ready     block can accept (registered state and rst only)
//   out_data     selected channel extended to OUT_WIDTH, or DEFAULT_VALUE
//   out_sel_err  out_data came from an out-of-range select
//   out_valid    out_data / out_sel_err are valid
//   out_ready    downstream accepts
//   err_clr      synchronous clear of err_count
//   err_count    saturating count of accepted out-of-range selects
// -----------------------------------------------------------------------------
module select_skid #(
    parameter int                   IN_CNT        = 4,
    parameter int                   IN_WIDTH      = 4,
    parameter int                   OUT_WIDTH     = 5,
    parameter int                   SEL_WIDTH     = 3,
    parameter logic [IN_CNT-1:0]    SIGNED_MASK   = 4'b1100,
    parameter logic [OUT_WIDTH-1:0] DEFAULT_VALUE = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [IN_CNT*IN_WIDTH-1:0]     in_data,
    input  logic [SEL_WIDTH-1:0]           in_sel,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic signed [OUT_WIDTH-1:0]    out_data,
    output logic                           out_sel_err,
    output logic                           out_valid,
    input  logic                           out_ready,
    input  logic                           err_clr,
    output logic [15:0]                    err_count
);

    typedef struct packed {
        logic [OUT_WIDTH-1:0] data;
        logic                 sel_err;
    } beat_t;

    beat_t       main_q, main_d;
    logic        main_valid_q, main_valid_d;
    beat_t       skid_q, skid_d;
    logic        skid_valid_q, skid_valid_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    beat_t                payload;
    logic [IN_WIDTH-1:0]  raw;
    logic                 raw_signed;
    logic                 sel_hit;
    logic                 accept;

    // Selection and extension of the offered beat.
    // NOTE: every variable written in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        raw        = '0;
        raw_signed = 1'b0;
        sel_hit    = 1'b0;
        for (int i = 0; i < IN_CNT; i++) begin
            if (in_sel == SEL_WIDTH'(i)) begin
                raw        = in_data[i*IN_WIDTH +: IN_WIDTH];
                raw_signed = SIGNED_MASK[i];
                sel_hit    = 1'b1;
            end
        end

        payload.data    = DEFAULT_VALUE;
        payload.sel_err = 1'b1;
        if (sel_hit) begin
            // Replicating (signed & msb) gives sign- or zero-extension in one
            // expression; OUT_WIDTH > IN_WIDTH keeps every value exact.
            payload.data    = {{(OUT_WIDTH-IN_WIDTH){raw_signed & raw[IN_WIDTH-1]}}, raw};
            payload.sel_err = 1'b0;
        end
    end

    // in_ready looks only at the skid flag: the main stage can always absorb
    // one more beat into the skid, so out_ready never needs to reach here.
    assign in_ready = !skid_valid_q && !rst;
    assign accept   = in_valid && in_ready;

    // Buffer next state.
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;

        if (!main_valid_q || out_ready) begin
            // Main is empty or drains this cycle. A full skid always refills
            // main first; it cannot coincide with an accept (in_ready=0).
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = payload;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            // Main is stalled; park the beat so out_data stays stable.
            skid_d       = payload;
            skid_valid_d = 1'b1;
        end
    end

    // Error counter: a clear takes priority but still counts a coincident
    // bad accept, so no error is lost across a clear.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = (accept && !sel_hit) ? 16'd1 : 16'd0;
        end else if (accept && !sel_hit && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign out_data    = main_q.data;
    assign out_sel_err = main_q.sel_err;
    assign out_valid   = main_valid_q;
    assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_select_skid.sv
// -----------------------------------------------------------------------------
// tb_select_skid
//
// Directed bench for select_skid with IN_CNT=4, IN_WIDTH=4, OUT_WIDTH=5,
// SEL_WIDTH=3, SIGNED_MASK=4'b1100, DEFAULT_VALUE=5'h0A. Inputs are driven
// and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_select_skid;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic [2:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic signed [4:0] out_data;
    logic        out_sel_err;
    logic        out_valid;
    logic        out_ready;
    logic        err_clr;
    logic [15:0] err_count;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    select_skid #(
        .IN_CNT        (4),
        .IN_WIDTH      (4),
        .OUT_WIDTH     (5),
        .SEL_WIDTH     (3),
        .SIGNED_MASK   (4'b1100),
        .DEFAULT_VALUE (5'h0A)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_sel      (in_sel),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_sel_err (out_sel_err),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .err_clr     (err_clr),
        .err_count   (err_count)
    );

    // Reference extension: channels 2 and 3 are two's complement, 0 and 1
    // unsigned, anything above 3 maps to the default value.
    function automatic logic [4:0] exp_ext(input logic [2:0] sel, input logic [15:0] d);
        logic [3:0] ch;
        int         v;
        if (sel > 3'd3) return 5'h0A;
        ch = d[sel*4 +: 4];
        v  = int'(ch);
        if (sel >= 3'd2 && v >= 8) v = v - 16;
        return 5'(v);
    endfunction

    task automatic offer(input logic [2:0] sel, input logic [15:0] d);
        in_sel   = sel;
        in_data  = d;
        in_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0;
        out_ready = 1'b0; err_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        vectors++; if (out_data !== 5'h00) begin miscompares++; $display("FAIL reset out_data: got %h want 00", out_data); end
        vectors++; if (out_sel_err !== 1'b0) begin miscompares++; $display("FAIL reset out_sel_err: got %b want 0", out_sel_err); end
        vectors++; if (err_count !== 16'h0000) begin miscompares++; $display("FAIL reset err_count: got %h want 0000", err_count); end
        rst = 1'b0;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL after_reset in_ready: got %b want 1", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL after_reset out_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_sign();
        out_ready = 1'b1;
        offer(3'd0, 16'h0008);
        @(negedge clk);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL sign_pos out_valid: got %b want 1", out_valid); end
        vectors++; if (out_data !== 5'b01000) begin miscompares++; $display("FAIL sign_pos out_data: got %b want 01000", out_data); end
        vectors++; if (out_sel_err !== 1'b0) begin miscompares++; $display("FAIL sign_pos out_sel_err: got %b want 0", out_sel_err); end
        offer(3'd2, 16'h0800);
        @(negedge clk);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL sign_neg out_valid: got %b want 1", out_valid); end
        vectors++; if (out_data !== 5'b11000) begin miscompares++; $display("FAIL sign_neg out_data: got %b want 11000", out_data); end
        vectors++; if (out_sel_err !== 1'b0) begin miscompares++; $display("FAIL sign_neg out_sel_err: got %b want 0", out_sel_err); end
        in_valid = 1'b0;
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL sign_drain out_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_out_of_range();
        out_ready = 1'b1;
        vectors++; if (err_count !== 16'd0) begin miscompares++; $display("FAIL oor_before err_count: got %h want 0000", err_count); end
        offer(3'd5, 16'hFFFF);
        @(negedge clk);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL oor out_valid: got %b want 1", out_valid); end
        vectors++; if (out_data !== 5'h0A) begin miscompares++; $display("FAIL oor out_data: got %h want 0a", out_data); end
        vectors++; if (out_sel_err !== 1'b1) begin miscompares++; $display("FAIL oor out_sel_err: got %b want 1", out_sel_err); end
        vectors++; if (err_count !== 16'd1) begin miscompares++; $display("FAIL oor err_count: got %h want 0001", err_count); end
        in_valid = 1'b0;
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL oor_drain out_valid: got %b want 0", out_valid); end
    endtask

    // A = ch1 5 -> 05, B = ch3 4'hB -> -5 = 1B, C = ch0 3 -> 03.
    task automatic test_back_pressure();
        out_ready = 1'b0;
        offer(3'd1, 16'h0050);
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_a in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_a out_valid: got %b want 1", out_valid); end
        vectors++; if (out_data !== 5'h05) begin miscompares++; $display("FAIL bp_a out_data: got %h want 05", out_data); end
        offer(3'd3, 16'hB000);
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_b in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_full in_ready: got %b want 0", in_ready); end
        vectors++; if (out_data !== 5'h05) begin miscompares++; $display("FAIL bp_hold1 out_data: got %h want 05", out_data); end
        offer(3'd0, 16'h0003);
        @(negedge clk);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold2 out_valid: got %b want 1", out_valid); end
        vectors++; if (out_data !== 5'h05) begin miscompares++; $display("FAIL bp_hold2 out_data: got %h want 05", out_data); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_hold2 in_ready: got %b want 0", in_ready); end
        out_ready = 1'b1;
        @(negedge clk);
        vectors++; if (out_data !== 5'h1B) begin miscompares++; $display("FAIL bp_out_b out_data: got %h want 1b", out_data); end
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_out_b out_valid: got %b want 1", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_reopen in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        vectors++; if (out_data !== 5'h03) begin miscompares++; $display("FAIL bp_out_c out_data: got %h want 03", out_data); end
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_out_c out_valid: got %b want 1", out_valid); end
        in_valid = 1'b0;
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain out_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_streaming();
        logic [4:0]  exp_prev;
        logic [2:0]  sel;
        logic [15:0] d;
        exp_prev  = '0;
        out_ready = 1'b1;
        for (int k = 0; k <= 100; k++) begin
            if (k > 0) begin
                vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stream[%0d] out_valid: got %b want 1", k, out_valid); end
                vectors++; if (out_data !== exp_prev) begin miscompares++; $display("FAIL stream[%0d] out_data: got %h want %h", k, out_data, exp_prev); end
                vectors++; if (out_sel_err !== 1'b0) begin miscompares++; $display("FAIL stream[%0d] out_sel_err: got %b want 0", k, out_sel_err); end
            end
            if (k < 100) begin
                vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stream[%0d] in_ready: got %b want 1", k, in_ready); end
                sel = 3'($urandom_range(0, 3));
                d   = 16'($urandom);
                offer(sel, d);
                exp_prev = exp_ext(sel, d);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_drain out_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_counter_edges();
        logic [2:0] bad_sels [3];
        bad_sels  = '{3'd6, 3'd7, 3'd4};
        out_ready = 1'b1;
        in_valid  = 1'b0;
        force dut.err_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.err_cnt_q;
        #1;
        vectors++; if (err_count !== 16'hFFFE) begin miscompares++; $display("FAIL cnt_preset err_count: got %h want fffe", err_count); end
        for (int i = 0; i < 3; i++) begin
            offer(bad_sels[i], 16'h1234);
            @(negedge clk);
            vectors++; if (err_count !== 16'hFFFF) begin miscompares++; $display("FAIL cnt_sat[%0d] err_count: got %h want ffff", i, err_count); end
            vectors++; if (out_sel_err !== 1'b1) begin miscompares++; $display("FAIL cnt_sat[%0d] out_sel_err: got %b want 1", i, out_sel_err); end
        end
        err_clr = 1'b1;
        offer(3'd5, 16'h0000);
        @(negedge clk);
        vectors++; if (err_count !== 16'd1) begin miscompares++; $display("FAIL cnt_clr_bad err_count: got %h want 0001", err_count); end
        in_valid = 1'b0;
        @(negedge clk);
        vectors++; if (err_count !== 16'd0) begin miscompares++; $display("FAIL cnt_clr err_count: got %h want 0000", err_count); end
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_flight();
        out_ready = 1'b0;
        offer(3'd1, 16'h0010);
        @(negedge clk);
        offer(3'd6, 16'h0000);
        @(negedge clk);
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rmf_full in_ready: got %b want 0", in_ready); end
        vectors++; if (err_count !== 16'd1) begin miscompares++; $display("FAIL rmf_full err_count: got %h want 0001", err_count); end
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rmf_rst_comb in_ready: got %b want 0", in_ready); end
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rmf_rst out_valid: got %b want 0", out_valid); end
        vectors++; if (out_data !== 5'h00) begin miscompares++; $display("FAIL rmf_rst out_data: got %h want 00", out_data); end
        vectors++; if (out_sel_err !== 1'b0) begin miscompares++; $display("FAIL rmf_rst out_sel_err: got %b want 0", out_sel_err); end
        vectors++; if (err_count !== 16'd0) begin miscompares++; $display("FAIL rmf_rst err_count: got %h want 0000", err_count); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rmf_rst in_ready: got %b want 0", in_ready); end
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rmf_after in_ready: got %b want 1", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rmf_after out_valid: got %b want 0", out_valid); end
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rmf_stale out_valid: got %b want 0", out_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_sign();
        test_out_of_range();
        test_back_pressure();
        test_streaming();
        test_counter_edges();
        test_reset_mid_flight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/select_skid.md
# select_skid

Parametrised N-way selector with per-input signedness, registered output and a two-entry valid/ready skid buffer. Each input channel is sign- or zero-extended to a common output width. Out-of-range selects produce a programmable default value, an error flag and a saturating error count. Sits between producer datapaths and a back-pressured consumer, replacing unregistered case-muxes where timing or flow control matters.

## Interface
- IN_CNT, 4: number of input channels, >= 2
- IN_WIDTH, 4: bits per input channel
- OUT_WIDTH, 5: output width; must be >= IN_WIDTH+1
- SEL_WIDTH, 3: select width; must be >= clog2(IN_CNT)
- SIGNED_MASK, 4'b1100: bit i = 1 means channel i is signed
- DEFAULT_VALUE, 0: output for out-of-range select, truncated to OUT_WIDTH
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  IN_CNT*IN_WIDTH  channel i at bits [i*IN_WIDTH +: IN_WIDTH]
- in_sel  input  SEL_WIDTH  channel select
- in_valid  input  1  upstream transfer request
- in_ready  output  1  block can accept
- out_data  output  OUT_WIDTH (signed)  extended selected value
- out_sel_err  output  1  out_data came from an out-of-range select
- out_valid  output  1  out_data/out_sel_err valid
- out_ready  input  1  downstream accepts
- err_clr  input  1  synchronous clear of err_count
- err_count  output  16  saturating count of accepted out-of-range selects

## Operation
- Accept: in_valid & in_ready at a rising edge. Transfer out: out_valid & out_ready.
- Extension at accept: channel in_sel with SIGNED_MASK[in_sel]=1 is sign-extended, else zero-extended, to OUT_WIDTH. Every input value is represented exactly.
- in_sel >= IN_CNT: payload = DEFAULT_VALUE[OUT_WIDTH-1:0], sel_err = 1. Never X.
- Storage: output register (main) plus one skid register, each holding {data, sel_err, valid}.
- in_ready = !skid_valid & !rst.
- Accept, main empty or draining this cycle, skid empty: payload goes to main.
- Accept while main holds data and out_ready=0: payload goes to skid.
- Main drains with skid full: skid moves to main, skid empties. in_ready rises next cycle.
- Ordering is strictly FIFO. No payload is dropped or duplicated.
- err_count: +1 on each accepted out-of-range select, saturates at 16'hFFFF.
  - err_clr alone sets it to 0.
  - err_clr together with an out-of-range accept sets it to 1.
- out_data and out_sel_err are held stable while out_valid=1 and out_ready=0.

## Timing
- Reset values: out_valid=0, out_data=0, out_sel_err=0, skid empty, err_count=0, in_ready=0 while rst is high.
- in_ready=1 in the first cycle after rst deasserts.
- Latency: accept at edge k gives out_valid=1 after edge k with the payload, provided main is empty.
- Throughput: one transfer per cycle when out_ready is held 1.
- After the skid fills, in_ready=0 until the first drain. in_ready returns to 1 one cycle after that drain.
- Combinational paths: in_ready depends only on registered state. No combinational path from out_ready to in_ready, or from in_* to out_*.
- rst mid-operation: all buffered payloads are discarded. Outputs return to reset values at the next edge, regardless of valid or ready.

## Test plan
- Sign handling. Defaults; send sel=0 with ch0=4'b1000, then sel=2 with ch2=4'b1000, out_ready=1. Required: out_data 5'b01000 (+8), then 5'b11000 (-8), each one cycle after accept, out_sel_err=0.
- Out-of-range select. sel=5, DEFAULT_VALUE=5'h0A. Required: out_data=5'h0A, out_sel_err=1, err_count 0 -> 1.
- Back-pressure and skid. out_ready=0; offer A(sel1), B(sel3), C(sel0) on consecutive cycles.
  - Required: A and B accepted, in_ready=0 when C is offered, out_data=A held stable.
  - Raise out_ready: outputs are A, B, C in order with no loss.
- Streaming. out_ready=1, 100 random accepted beats. Required: 100 outputs, in order, 1-cycle latency, in_ready constantly 1.
- Counter edges. Force err_count=16'hFFFE, send 3 bad selects. Required: saturates at FFFF. Then err_clr with a simultaneous bad accept gives err_count=1.
- Reset mid-flight. Main and skid full, assert rst for one cycle. Required: out_valid=0, err_count=0, in_ready=0 during rst; in_ready=1 the following cycle; no stale data emitted.
